// File: rtl/uart_tx_arb.sv
// Three-requester character arbiter feeding a UART TX FIFO: round-robin, one character per two cycles.
// Optional line locking (requester keeps the line until it sends 8'h0A or goes idle) under `UART_ARB_LOCK_EN.
module uart_tx_arb #(
  parameter logic [15:0] LOCK_TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_char,
  output logic [2:0]  req_ready,
  output logic [7:0]  uart_io_char,
  output logic        uart_io_we,
  input  logic        uart_io_full,
  output logic [1:0]  grant_id,
  output logic        busy
);

`ifdef UART_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GAP = 2'd1, LOCK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GAP = 2'd1} state_t;
`endif

  state_t      state_reg;
  state_t      state_next;
  logic [1:0]  last_grant_reg;
  logic [7:0]  char_reg;
  logic [1:0]  grant_reg;
  logic        we_reg;

  logic [1:0]  rr_first;
  logic [2:0]  rr_ready;
  logic        accept;
  logic [1:0]  acc_id;
  logic [7:0]  acc_char;

`ifdef UART_ARB_LOCK_EN
  logic [15:0] lock_cnt_reg;
  logic        lock_expire;
  assign lock_expire = (lock_cnt_reg == LOCK_TIMEOUT - 16'd1);
`else
  logic        unused_timeout;
  assign unused_timeout = ^LOCK_TIMEOUT;
`endif

  // Round-robin search starts just after the last granted requester.
  assign rr_first = (last_grant_reg == 2'd2) ? 2'd0 : last_grant_reg + 2'd1;

  always_comb begin : rr_search
    logic [1:0] cand;
    logic       found;
    rr_ready = 3'b000;
    found    = 1'b0;
    cand     = rr_first;
    for (int k = 0; k < 3; k++) begin
      if (!found && req_valid[cand]) begin
        rr_ready[cand] = 1'b1;
        found          = 1'b1;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  always_comb begin
    req_ready = 3'b000;
    if (!rst && !uart_io_full) begin
      case (state_reg)
        IDLE: req_ready = rr_ready;
`ifdef UART_ARB_LOCK_EN
        // While locked, grant_reg still names the lock owner.
        LOCK: req_ready[grant_reg] = req_valid[grant_reg];
`endif
        default: req_ready = 3'b000;
      endcase
    end
  end

  assign accept = |req_ready;

  always_comb begin
    acc_id   = 2'd0;
    acc_char = req_char[7:0];
    if (req_ready[1]) begin
      acc_id   = 2'd1;
      acc_char = req_char[15:8];
    end else if (req_ready[2]) begin
      acc_id   = 2'd2;
      acc_char = req_char[23:16];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = GAP;
`ifdef UART_ARB_LOCK_EN
      GAP:  state_next = (char_reg != 8'h0A) ? LOCK : IDLE;
      LOCK: begin
        if (accept) state_next = GAP;
        else if (lock_expire) state_next = IDLE;
      end
`else
      GAP:  state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 2'd2;
      char_reg       <= 8'd0;
      grant_reg      <= 2'd0;
      we_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      we_reg    <= accept;
      if (accept) begin
        last_grant_reg <= acc_id;
        char_reg       <= acc_char;
        grant_reg      <= acc_id;
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_reg <= 16'd0;
    end else if (accept) begin
      lock_cnt_reg <= 16'd0;
    end else if (state_reg == LOCK) begin
      lock_cnt_reg <= lock_cnt_reg + 16'd1;
    end
  end
`endif

  // A write still pending when reset arrives is suppressed, not delivered.
  assign uart_io_we   = we_reg & ~rst;
  assign uart_io_char = char_reg;
  assign grant_id     = grant_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized and directed bench for uart_tx_arb against a cycle-level behavioural model.
// Requesters are modelled as character FIFOs; every write is logged and printed.
module tb_uart_tx_arb;

  localparam logic [15:0] TMO = 16'd8;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [23:0] req_char;
  logic [2:0]  req_ready;
  logic [7:0]  uart_io_char;
  logic        uart_io_we;
  logic        uart_io_full;
  logic [1:0]  grant_id;
  logic        busy;

  uart_tx_arb #(.LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_char(req_char),
    .req_ready(req_ready), .uart_io_char(uart_io_char), .uart_io_we(uart_io_we),
    .uart_io_full(uart_io_full), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // requester FIFOs
  logic [7:0] src_buf [3][64];
  int head [3];
  int tail [3];
  logic [2:0] drop_mask;

  // write log
  int         wr_cyc [$];
  logic [7:0] wr_char [$];
  logic [1:0] wr_gid [$];

  // behavioural model
  bit         m_gap;
  int         m_lock;
  int         m_pend;
  int         m_cnt;
  int         m_last;
  bit         m_we;
  logic [7:0] m_char;
  logic [1:0] m_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_gap = 0; m_lock = -1; m_pend = -1; m_cnt = 0; m_last = 2;
    m_we = 0; m_char = 8'd0; m_grant = 2'd0;
  endfunction

  task automatic push(input int i, input logic [7:0] c);
    src_buf[i][tail[i] % 64] = c;
    tail[i]++;
  endtask

  task automatic flush_src();
    for (int i = 0; i < 3; i++) head[i] = tail[i];
  endtask

  task automatic clear_log();
    wr_cyc.delete(); wr_char.delete(); wr_gid.delete();
  endtask

  task automatic run_cycle();
    logic [2:0] exp_ready;
    logic [7:0] sel_char;
    int sel;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = (head[i] != tail[i]) && !drop_mask[i];
      req_char[8*i +: 8] = src_buf[i][head[i] % 64];
    end
    #1;
    exp_ready = 3'b000;
    sel = -1;
    if (!rst && !uart_io_full && !m_gap) begin
      if (m_lock >= 0) begin
        if (req_valid[m_lock]) sel = m_lock;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          int j;
          j = (m_last + k) % 3;
          if (sel < 0 && req_valid[j]) sel = j;
        end
      end
    end
    if (sel >= 0) exp_ready[sel] = 1'b1;
    check("ready", 32'(req_ready), 32'(exp_ready));
    check("we", 32'(uart_io_we), 32'(m_we && !rst));
    check("char", 32'(uart_io_char), 32'(m_char));
    check("gid", 32'(grant_id), 32'(m_grant));
    check("busy", 32'(busy), 32'(m_gap || m_lock >= 0));
    if (uart_io_we) begin
      wr_cyc.push_back(cyc); wr_char.push_back(uart_io_char); wr_gid.push_back(grant_id);
      $display("wr cyc=%0d gid=%0d char=%02h", cyc, grant_id, uart_io_char);
    end
    for (int i = 0; i < 3; i++) if (req_valid[i] && req_ready[i]) head[i]++;
    if (rst) begin
      model_reset();
    end else if (sel >= 0) begin
      sel_char = req_char[8*sel +: 8];
      m_we = 1; m_char = sel_char; m_grant = 2'(sel); m_last = sel;
      m_gap = 1; m_cnt = 0; m_lock = -1;
`ifdef UART_ARB_LOCK_EN
      m_pend = (sel_char != 8'h0A) ? sel : -1;
`else
      m_pend = -1;
`endif
    end else begin
      m_we = 0;
      if (m_gap) begin
        m_gap = 0;
        m_lock = m_pend;
      end else if (m_lock >= 0) begin
        m_cnt++;
        if (m_cnt == int'(TMO)) m_lock = -1;
      end
    end
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic do_reset();
    flush_src();
    drop_mask = 3'b000;
    uart_io_full = 1'b0;
    rst = 1'b1;
    run_cycle();
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rst = 1'b1; uart_io_full = 1'b0; req_valid = 3'b000; req_char = 24'd0; drop_mask = 3'b000;
    for (int i = 0; i < 3; i++) begin head[i] = 0; tail[i] = 0; end
    repeat (2) @(posedge clk);
    #2;
    model_reset();
    do_reset();

    // all three valid with 'A','B','C'
    clear_log();
    for (int n = 0; n < 4; n++) begin push(0, "A"); push(1, "B"); push(2, "C"); end
    repeat (8) run_cycle();
    check("rot_count", 32'(wr_cyc.size()), 32'd4);
    if (wr_cyc.size() == 4) begin
      logic [1:0] exp_g [4];
`ifdef UART_ARB_LOCK_EN
      exp_g = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
      exp_g = '{2'd0, 2'd1, 2'd2, 2'd0};
`endif
      for (int n = 0; n < 4; n++) check("rot_gid", 32'(wr_gid[n]), 32'(exp_g[n]));
      for (int n = 1; n < 4; n++) check("rot_gap", 32'(wr_cyc[n] - wr_cyc[n-1]), 32'd2);
    end

    // FIFO full stall with req0 holding 'x'
    do_reset();
    clear_log();
    uart_io_full = 1'b1;
    push(0, "x");
    repeat (10) begin
      run_cycle();
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    uart_io_full = 1'b0;
    repeat (4) run_cycle();
    check("stall_writes", 32'(wr_cyc.size()), 32'd1);
    if (wr_cyc.size() >= 1) check("stall_char", 32'(wr_char[0]), 32'h78);

    // reset during the GAP after accepting 'z'
    do_reset();
    clear_log();
    start = head[1];
    push(1, "z");
    for (int n = 0; n < 5 && head[1] == start; n++) run_cycle();
    check("z_accept", 32'(head[1] - start), 32'd1);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    #1;
    check("z_dropped", 32'(wr_cyc.size()), 32'd0);
    check("post_rst_we", 32'(uart_io_we), 32'd0);
    check("post_rst_char", 32'(uart_io_char), 32'd0);
    check("post_rst_gid", 32'(grant_id), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    push(0, "p"); push(1, "q");
    repeat (6) run_cycle();
    check("post_rst_first", 32'(wr_cyc.size() > 0 ? wr_gid[0] : 2'd3), 32'd0);

`ifdef UART_ARB_LOCK_EN
    // req1 sends "hi\n" while req0 waits
    do_reset();
    clear_log();
    push(1, "h"); push(1, "i"); push(1, 8'h0A);
    run_cycle();
    push(0, "Q");
    repeat (10) run_cycle();
    check("lock_count", 32'(wr_cyc.size()), 32'd4);
    if (wr_cyc.size() == 4) begin
      logic [7:0] exp_c [4];
      logic [1:0] exp_g [4];
      exp_c = '{8'h68, 8'h69, 8'h0A, 8'h51};
      exp_g = '{2'd1, 2'd1, 2'd1, 2'd0};
      for (int n = 0; n < 4; n++) begin
        check("lock_char", 32'(wr_char[n]), 32'(exp_c[n]));
        check("lock_gid", 32'(wr_gid[n]), 32'(exp_g[n]));
      end
    end

    // lock timeout: req2 sends 'a' then goes idle
    do_reset();
    clear_log();
    push(2, "a");
    run_cycle();
    push(0, "Q");
    repeat (14) run_cycle();
    check("tmo_count", 32'(wr_cyc.size()), 32'd2);
    if (wr_cyc.size() == 2) begin
      check("tmo_delay", 32'(wr_cyc[1] - wr_cyc[0]), 32'd10);
      check("tmo_gid", 32'(wr_gid[1]), 32'd0);
    end
`else
    // req1 streams 'a','b' while req0 stays valid
    do_reset();
    push(0, "k");
    repeat (3) run_cycle();
    clear_log();
    for (int n = 0; n < 3; n++) push(0, "r");
    push(1, "a"); push(1, "b");
    repeat (8) run_cycle();
    check("ilv_count", 32'(wr_cyc.size() >= 3), 32'd1);
    if (wr_cyc.size() >= 3) begin
      logic [7:0] exp_c [3];
      logic [1:0] exp_g [3];
      exp_c = '{8'h61, 8'h72, 8'h62};
      exp_g = '{2'd1, 2'd0, 2'd1};
      for (int n = 0; n < 3; n++) begin
        check("ilv_gid", 32'(wr_gid[n]), 32'(exp_g[n]));
        check("ilv_char", 32'(wr_char[n]), 32'(exp_c[n]));
      end
    end
`endif

    // randomized traffic with full, valid drops and occasional reset
    do_reset();
    clear_log();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ((tail[i] - head[i]) < 60 && $urandom_range(3) == 0)
          push(i, ($urandom_range(4) == 0) ? 8'h0A : 8'($urandom_range(8'h20, 8'h7E)));
        drop_mask[i] = ($urandom_range(7) == 0);
      end
      uart_io_full = ($urandom_range(4) == 0);
      rst = ($urandom_range(149) == 0);
      run_cycle();
    end
    rst = 1'b0;
    uart_io_full = 1'b0;
    drop_mask = 3'b000;
    repeat (20) run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter LOCK_TIMEOUT, default 16'd50000, which sets the number of idle cycles after which a line lock is dropped.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port req_valid, input, 3 bits: character-request valid per requester (0 = CPU IO write, 1 = monitor echo-back, 2 = debug trace).
REQ-005 The block SHALL have port req_char, input, 24 bits: character per requester; requester i uses bits [8i+7:8i].
REQ-006 The block SHALL have port req_ready, output, 3 bits: one-hot acceptance strobe per requester.
REQ-007 The block SHALL have port uart_io_char, output, 8 bits: character to the UART TX FIFO.
REQ-008 The block SHALL have port uart_io_we, output, 1 bit: one-cycle write strobe to the UART TX FIFO.
REQ-009 The block SHALL have port uart_io_full, input, 1 bit: UART TX FIFO full.
REQ-010 The block SHALL have port grant_id, output, 2 bits: requester index of the character currently on uart_io_char.
REQ-011 The block SHALL have port busy, output, 1 bit: high when the block is in GAP or LOCK state.

Function
REQ-012 The handshake SHALL be valid/ready: a character is accepted in a cycle where req_valid[i] and req_ready[i] are both high, and requester i SHALL hold valid and char stable until accepted.
REQ-013 req_ready SHALL be combinational, at most one bit high, and all bits low whenever uart_io_full=1, state=GAP, or rst=1.
REQ-014 The FSM SHALL have states IDLE, GAP and LOCK: IDLE/LOCK -> GAP on acceptance; GAP -> IDLE or LOCK (REQ-019) after exactly one cycle; with no acceptance the state SHALL hold.
REQ-015 Latency SHALL be fixed: acceptance in cycle t gives uart_io_we=1, uart_io_char=accepted char and grant_id=i in cycle t+1.
REQ-016 uart_io_we SHALL be a single-cycle pulse, and uart_io_char and grant_id SHALL hold their values until the next acceptance.
REQ-017 Throughput SHALL be at most one character per 2 cycles; the GAP cycle absorbs the one-cycle update lag of uart_io_full.
REQ-018 In IDLE, selection SHALL be round-robin: search order starts at last_grant+1 mod 3 and wraps 2->0; last_grant updates on each acceptance.
REQ-019 In LOCK, only the locked requester SHALL be eligible; other requesters' valid is ignored.
REQ-020 uart_io_full rising while a requester is valid SHALL stall it with no drop and no duplicate; acceptance resumes in the first cycle with full=0 and state≠GAP.
REQ-021 req_valid dropping without acceptance SHALL cause no output.
REQ-022 Simultaneous valid from all three requesters SHALL be served in strict rotation, one character each.

Reset
REQ-023 With rst=1 at a clock edge, the block SHALL go to state IDLE, with last_grant=2 (requester 0 first), uart_io_char=8'd0, uart_io_we=0, grant_id=2'd0, busy=0, lock counter=0.
REQ-024 Reset mid-GAP or mid-LOCK SHALL abandon the lock, and any character accepted in the reset cycle SHALL NOT be written.

Configuration
REQ-025 With macro UART_ARB_LOCK_EN defined, accepting a character other than 8'h0A from requester i SHALL lock the block to i (GAP -> LOCK); accepting 8'h0A SHALL release it (GAP -> IDLE).
REQ-026 With UART_ARB_LOCK_EN defined, a 16-bit lock counter SHALL clear on each acceptance and increment each LOCK cycle; reaching LOCK_TIMEOUT SHALL force LOCK -> IDLE.
REQ-027 Without UART_ARB_LOCK_EN, the LOCK state and counter SHALL be absent, GAP SHALL always return to IDLE, and arbitration SHALL happen on every character.

Verification
REQ-028 After reset, req_valid=3'b111, chars 'A','B','C', full=0: the bench SHALL check uart_io_we pulses every 2 cycles with grant_id sequence 0,1,2,0.
REQ-029 Hold uart_io_full=1 for 10 cycles with req0 valid 'x': the bench SHALL check req_ready=0 throughout, then exactly one write of 8'h78 after full drops.
REQ-030 With UART_ARB_LOCK_EN, req1 sends "hi\n" while req0 is valid: the bench SHALL check writes 'h','i',8'h0A all with grant_id=1, then a req0 write.
REQ-031 With UART_ARB_LOCK_EN and LOCK_TIMEOUT=8, req2 sends 'a' then goes idle while req0 is valid: the bench SHALL check req0 is accepted 8 cycles after LOCK is entered.
REQ-032 Assert rst in the GAP cycle following acceptance of 'z': the bench SHALL check no uart_io_we pulse, outputs at reset values, and next grant to requester 0.
REQ-033 Without the macro, req1 streams 'a','b' with req0 valid: the bench SHALL check grants interleave 1,0,1.
